// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Common Data Bus arbiter: per-port completion queues, round-robin grant, registered broadcast.
module cdb_arbiter #(
  parameter int N_PORTS    = 4,
  parameter int QDEPTH     = 2,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           flush,
  input  logic [N_PORTS-1:0]             fu_valid,
  input  logic [N_PORTS*TAG_WIDTH-1:0]   fu_tag,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  fu_data,
  output logic [N_PORTS-1:0]             fu_ready,
  output logic                           cdb_valid,
  output logic [TAG_WIDTH-1:0]           cdb_tag,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic [$clog2(N_PORTS)-1:0]     cdb_src
);

  localparam int SW = $clog2(N_PORTS);
  localparam int IW = $clog2(QDEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]         wr_ptr_q [N_PORTS];
  logic [PW-1:0]         wr_ptr_d [N_PORTS];
  logic [PW-1:0]         rd_ptr_q [N_PORTS];
  logic [PW-1:0]         rd_ptr_d [N_PORTS];
  logic [TAG_WIDTH-1:0]  tag_mem_q  [N_PORTS][QDEPTH];
  logic [TAG_WIDTH-1:0]  tag_mem_d  [N_PORTS][QDEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [N_PORTS][QDEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [N_PORTS][QDEPTH];
  logic [SW-1:0]         rr_q, rr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [SW-1:0]         cdb_src_q, cdb_src_d;

  logic [N_PORTS-1:0]    full;
  logic [N_PORTS-1:0]    empty;
  logic                  found;
  logic [SW-1:0]         grant;
  logic [SW-1:0]         cand;
  int                    idx;

  // Full means same slot index but opposite wrap bit; ready ignores any same-cycle pop.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
      full[p]  = (wr_ptr_q[p][IW-1:0] == rd_ptr_q[p][IW-1:0]) &&
                 (wr_ptr_q[p][IW] != rd_ptr_q[p][IW]);
    end
    fu_ready = (i_rst_n && !flush) ? ~full : '0;
  end

  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      cand = SW'(idx);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_mem_d   = tag_mem_q;
    data_mem_d  = data_mem_q;
    rr_d        = rr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      for (int p = 0; p < N_PORTS; p++) begin
        wr_ptr_d[p] = '0;
        rd_ptr_d[p] = '0;
      end
      rr_d = '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (fu_valid[p] && fu_ready[p]) begin
          tag_mem_d[p][wr_ptr_q[p][IW-1:0]]  = fu_tag[p*TAG_WIDTH +: TAG_WIDTH];
          data_mem_d[p][wr_ptr_q[p][IW-1:0]] = fu_data[p*DATA_WIDTH +: DATA_WIDTH];
          wr_ptr_d[p] = wr_ptr_q[p] + PW'(1);
        end
      end
      // Head is read from the pre-edge array, so a same-cycle push never overtakes it.
      if (found) begin
        rd_ptr_d[grant] = rd_ptr_q[grant] + PW'(1);
        cdb_valid_d     = 1'b1;
        cdb_tag_d       = tag_mem_q[grant][rd_ptr_q[grant][IW-1:0]];
        cdb_data_d      = data_mem_q[grant][rd_ptr_q[grant][IW-1:0]];
        cdb_src_d       = grant;
        rr_d            = (grant == SW'(N_PORTS - 1)) ? '0 : grant + SW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int p = 0; p < N_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        for (int e = 0; e < QDEPTH; e++) begin
          tag_mem_q[p][e]  <= '0;
          data_mem_q[p][e] <= '0;
        end
      end
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_mem_q   <= tag_mem_d;
      data_mem_q  <= data_mem_d;
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - Randomized scoreboard bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int QD = 2;
  localparam int TW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    fu_valid = '0;
  logic [N*TW-1:0] fu_tag = '0;
  logic [N*DW-1:0] fu_data = '0;
  logic [N-1:0]    fu_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_PORTS(N), .QDEPTH(QD), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .flush(flush),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  typedef struct {
    int            src;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } res_t;

  res_t mq [N][$];
  res_t exp_q [$];
  int   rr_m = 0;
  logic exp_valid = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each port is a bounded FIFO; the winner is the first non-empty port from rr upward.
  always @(posedge clk) begin : model
    int   win;
    res_t r;
    if (!rst_n) begin
      for (int p = 0; p < N; p++) mq[p].delete();
      rr_m = 0;
      exp_valid = 1'b0;
    end else if (flush) begin
      for (int p = 0; p < N; p++) mq[p].delete();
      rr_m = 0;
      exp_valid = 1'b0;
    end else begin
      win = -1;
      for (int i = 0; i < N; i++)
        if (win < 0 && mq[(rr_m + i) % N].size() > 0) win = (rr_m + i) % N;
      for (int p = 0; p < N; p++) begin
        if (fu_valid[p] && mq[p].size() < QD) begin
          r.src  = p;
          r.tag  = fu_tag[p*TW +: TW];
          r.data = fu_data[p*DW +: DW];
          mq[p].push_back(r);
        end
      end
      if (win >= 0) begin
        r = mq[win].pop_front();
        exp_q.push_back(r);
        rr_m = (win + 1) % N;
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [N-1:0] er;
    res_t         e;
    if (!rst_n) begin
      check("rst_cdb_valid", cdb_valid, 0);
      check("rst_cdb_tag", cdb_tag, 0);
      check("rst_cdb_data", cdb_data, 0);
      check("rst_cdb_src", cdb_src, 0);
      check("rst_fu_ready", fu_ready, 0);
      exp_q.delete();
    end else begin
      for (int p = 0; p < N; p++) er[p] = !flush && (mq[p].size() < QD);
      check("fu_ready", fu_ready, er);
      check("cdb_valid", cdb_valid, exp_valid);
      if (exp_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (cdb_valid) begin
          check("cdb_tag", cdb_tag, e.tag);
          check("cdb_data", cdb_data, e.data);
          check("cdb_src", cdb_src, e.src);
        end
      end else if (!cdb_valid) begin
        check("idle_cdb_tag", cdb_tag, 0);
        check("idle_cdb_data", cdb_data, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int p, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    fu_valid[p] = v;
    fu_tag[p*TW +: TW] = t;
    fu_data[p*DW +: DW] = d;
  endtask

  task automatic idle(input int n);
    fu_valid = '0;
    flush = 1'b0;
    repeat (n) step();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int   sent;
    int   budget;
    logic acc;

    rst_n = 1'b0;
    fu_valid = '1;
    repeat (3) step();
    rst_n = 1'b1;
    idle(4);

    set_port(2, 1'b1, 6'h15, 32'hDEADBEEF);
    step();
    idle(4);

    for (int p = 0; p < N; p++) set_port(p, 1'b1, TW'(p + 1), $urandom);
    step();
    idle(6);

    for (int k = 0; k < 8; k++) begin
      set_port(1, 1'b1, TW'(8 + k), $urandom);
      set_port(3, 1'b1, TW'(24 + k), $urandom);
      step();
    end
    idle(6);

    sent = 0;
    budget = 0;
    while (sent < 4 && budget < 60) begin
      set_port(0, 1'b1, TW'(16 + sent), $urandom);
      for (int p = 1; p < N; p++) set_port(p, 1'b1, TW'($urandom), $urandom);
      #1;
      acc = fu_ready[0];
      step();
      if (acc) sent++;
      budget++;
    end
    check("backpressure_sent", sent, 4);
    idle(10);

    set_port(1, 1'b1, 6'h20, $urandom);
    step();
    set_port(1, 1'b1, 6'h21, $urandom);
    step();
    idle(4);

    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < N; p++) set_port(p, 1'b1, TW'(48 + 4 * k + p), $urandom);
      step();
    end
    fu_valid = '0;
    set_port(2, 1'b1, 6'h2A, $urandom);
    flush = 1'b1;
    step();
    flush = 1'b0;
    fu_valid = '0;
    set_port(3, 1'b1, 6'h3F, $urandom);
    step();
    idle(4);

    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < N; p++)
        set_port(p, $urandom_range(0, 99) < 60, TW'($urandom), $urandom);
      flush = ($urandom_range(0, 99) < 3);
      if (k == 200) rst_n = 1'b0;
      if (k == 203) rst_n = 1'b1;
      step();
    end
    idle(12);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
